// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter sequencer.
// Holds the FSM state enum and the redirect-source encoding.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAIT,
    ST_TRAP
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_TRAP,
    SRC_MRET,
    SRC_JALR,
    SRC_BR
  } redir_src_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational redirect arbitration: trap > mret > jalr > branch.
// Flags a non-trap target that violates the fetch alignment.
module pc_target_sel
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int C_EXT = 0
) (
  input  logic            trap_req,
  input  logic            mret,
  input  logic            jalr_en,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic [XLEN-1:0] epc,
  output redir_src_t      src,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum = jalr_base + jalr_imm;

  always_comb begin
    src    = SRC_NONE;
    target = br_target;
    if (trap_req) begin
      src = SRC_TRAP;
    end else if (mret) begin
      src    = SRC_MRET;
      target = epc;
    end else if (jalr_en) begin
      src    = SRC_JALR;
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (br_taken) begin
      src = SRC_BR;
    end
  end

  // Bit 1 only matters when compressed instructions are not supported.
  always_comb begin
    misalign = 1'b0;
    if (src != SRC_NONE && src != SRC_TRAP) begin
      misalign = target[0] | ((C_EXT == 0) & target[1]);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, prioritised redirects,
// redirect parking while imem is busy, and trap/mret handling.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              C_EXT     = 0
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic            trap_req,
  input  logic            mret,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            misalign
);

  pc_state_t       state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] epc_reg, epc_next;
  logic [XLEN-1:0] pend_reg, pend_next;
  logic            misalign_reg, misalign_next;

  redir_src_t      sel_src;
  logic [XLEN-1:0] sel_target;
  logic            sel_misalign;
  logic            fire;

  pc_target_sel #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_target_sel (
    .trap_req  (trap_req),
    .mret      (mret),
    .jalr_en   (jalr_en),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jalr_base (jalr_base),
    .jalr_imm  (jalr_imm),
    .epc       (epc_reg),
    .src       (sel_src),
    .target    (sel_target),
    .misalign  (sel_misalign)
  );

  assign pc       = pc_reg;
  assign epc      = epc_reg;
  assign misalign = misalign_reg;
  assign pc_plus4 = pc_reg + XLEN'(4);
  assign pc_valid = (state_reg == ST_RUN) || (state_reg == ST_WAIT);
  assign fire     = pc_valid & imem_ready & ~stall;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    epc_next      = epc_reg;
    pend_next     = pend_reg;
    misalign_next = 1'b0;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_TRAP: begin
        pc_next    = TRAP_VEC;
        state_next = ST_RUN;
      end
      ST_RUN, ST_WAIT: begin
        // A misaligned target is converted into a trap instead of being loaded.
        if (sel_src == SRC_TRAP || sel_misalign) begin
          epc_next      = pc_reg;
          misalign_next = sel_misalign;
          state_next    = ST_TRAP;
        end else if (sel_src != SRC_NONE) begin
          if (imem_ready) begin
            pc_next    = sel_target;
            state_next = ST_RUN;
          end else begin
            pend_next  = sel_target;
            state_next = ST_WAIT;
          end
        end else if (state_reg == ST_WAIT) begin
          if (imem_ready) begin
            pc_next    = pend_reg;
            state_next = ST_RUN;
          end
        end else if (fire) begin
          pc_next = pc_plus4;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_VEC;
      epc_reg      <= '0;
      pend_reg     <= '0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      epc_reg      <= epc_next;
      pend_reg     <= pend_next;
      misalign_reg <= misalign_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_V  = 32'h0;
  localparam logic [31:0] TRAP_V = 32'h100;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        stall = 1'b0, br_taken = 1'b0, jalr_en = 1'b0;
  logic        trap_req = 1'b0, mret = 1'b0, imem_ready = 1'b1;
  logic [31:0] br_target = '0, jalr_base = '0, jalr_imm = '0;
  logic [31:0] pc, pc_plus4, epc;
  logic        pc_valid, misalign;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: fetch address, saved epc, parked target and phase flags.
  logic [31:0] m_pc, m_epc, m_pend;
  bit          m_boot, m_trap, m_wait, m_mis;

  pc_sequencer #(
    .XLEN(32), .RESET_VEC(RST_V), .TRAP_VEC(TRAP_V), .C_EXT(0)
  ) dut (
    .clk(clk), .n_rst(n_rst), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jalr_en(jalr_en), .jalr_base(jalr_base),
    .jalr_imm(jalr_imm), .trap_req(trap_req), .mret(mret),
    .imem_ready(imem_ready), .pc(pc), .pc_valid(pc_valid),
    .pc_plus4(pc_plus4), .epc(epc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RST_V; m_epc = '0; m_pend = '0;
    m_boot = 1; m_trap = 0; m_wait = 0; m_mis = 0;
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; jalr_en = 0; trap_req = 0; mret = 0;
  endtask

  // One clock: model computes its successor from the inputs seen at the edge.
  task automatic advance();
    logic [31:0] n_pc, n_epc, n_pend, tgt;
    bit n_boot, n_trap, n_wait, n_mis, have, take_trap;
    n_pc = m_pc; n_epc = m_epc; n_pend = m_pend;
    n_boot = m_boot; n_trap = m_trap; n_wait = m_wait; n_mis = 0;
    tgt = '0; have = 0; take_trap = 0;
    if (m_boot) begin
      n_boot = 0;
    end else if (m_trap) begin
      n_trap = 0; n_pc = TRAP_V;
    end else begin
      if (trap_req) take_trap = 1;
      else if (mret) begin tgt = m_epc; have = 1; end
      else if (jalr_en) begin tgt = (jalr_base + jalr_imm) & ~32'h1; have = 1; end
      else if (br_taken) begin tgt = br_target; have = 1; end
      if (have && tgt[1:0] != 2'b00) begin take_trap = 1; n_mis = 1; end
      if (take_trap) begin
        n_epc = m_pc; n_trap = 1; n_wait = 0;
      end else if (have) begin
        if (imem_ready) begin n_pc = tgt; n_wait = 0; end
        else begin n_pend = tgt; n_wait = 1; end
      end else if (m_wait) begin
        if (imem_ready) begin n_pc = m_pend; n_wait = 0; end
      end else if (imem_ready && !stall) begin
        n_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    if (!n_rst) model_reset();
    else begin
      m_pc = n_pc; m_epc = n_epc; m_pend = n_pend;
      m_boot = n_boot; m_trap = n_trap; m_wait = n_wait; m_mis = n_mis;
    end
    #1;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    clear_inputs(); imem_ready = 1; br_taken = 1; br_target = addr;
    advance();
    clear_inputs();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    clear_inputs(); imem_ready = 1; n_rst = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    vectors++;
    if (pc !== RST_V || pc_valid !== 1'b0 || epc !== 32'h0 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h valid=%b epc=%h mis=%b, want %h 0 0 0", pc, pc_valid, epc, misalign, RST_V);
    end
    n_rst = 1;
    #1;
    vectors++;
    if (pc !== 32'h0 || pc_valid !== 1'b0) begin
      miscompares++; $display("FAIL boot_cycle: pc=%h valid=%b, want 0 0", pc, pc_valid);
    end
    for (int i = 0; i < 4; i++) begin
      advance();
      vectors++;
      if (pc !== exp_pc[i] || pc_valid !== 1'b1) begin
        miscompares++; $display("FAIL seq[%0d]: pc=%h valid=%b, want %h 1", i, pc, pc_valid, exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirects();
    jump_to(32'h40);
    stall = 1; br_taken = 1; br_target = 32'h80;
    advance(); clear_inputs();
    vectors++;
    if (pc !== 32'h80) begin miscompares++; $display("FAIL br_over_stall: pc=%h, want 00000080", pc); end
    imem_ready = 0; jalr_en = 1; jalr_base = 32'h100; jalr_imm = 32'h11;
    advance(); clear_inputs();
    vectors++;
    if (pc !== 32'h80 || pc_valid !== 1'b1) begin
      miscompares++; $display("FAIL jalr_wait_hold: pc=%h valid=%b, want 00000080 1", pc, pc_valid);
    end
    imem_ready = 1;
    advance();
    vectors++;
    if (pc !== 32'h110) begin miscompares++; $display("FAIL jalr_release: pc=%h, want 00000110", pc); end
    jump_to(32'h30);
    trap_req = 1; br_taken = 1; br_target = 32'h200;
    advance(); clear_inputs();
    vectors++;
    if (pc_valid !== 1'b0 || epc !== 32'h30) begin
      miscompares++; $display("FAIL trap_prio: valid=%b epc=%h, want 0 00000030", pc_valid, epc);
    end
    advance(); advance();
    vectors++;
    if (pc !== TRAP_V + 32'd4) begin miscompares++; $display("FAIL trap_exit: pc=%h, want %h", pc, TRAP_V + 32'd4); end
    mret = 1;
    advance(); clear_inputs();
    vectors++;
    if (pc !== 32'h30 || epc !== 32'h30) begin
      miscompares++; $display("FAIL mret: pc=%h epc=%h, want 00000030 00000030", pc, epc);
    end
  endtask

  task automatic test_misalign();
    jump_to(32'h20);
    br_taken = 1; br_target = 32'h82;
    advance(); clear_inputs();
    vectors++;
    if (misalign !== 1'b1 || epc !== 32'h20 || pc_valid !== 1'b0) begin
      miscompares++; $display("FAIL misalign_pulse: mis=%b epc=%h valid=%b, want 1 00000020 0", misalign, epc, pc_valid);
    end
    advance();
    vectors++;
    if (misalign !== 1'b0 || pc !== TRAP_V || pc_valid !== 1'b1) begin
      miscompares++; $display("FAIL misalign_exit: mis=%b pc=%h valid=%b, want 0 %h 1", misalign, pc, pc_valid, TRAP_V);
    end
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    vectors++;
    if (pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL plus4_wrap: pc_plus4=%h, want 00000000", pc_plus4); end
    advance();
    vectors++;
    if (pc !== 32'h0) begin miscompares++; $display("FAIL pc_wrap: pc=%h, want 00000000", pc); end
  endtask

  task automatic test_back_to_back();
    imem_ready = 0; br_taken = 1; br_target = 32'h400;
    advance();
    br_target = 32'h500;
    advance(); clear_inputs();
    imem_ready = 1;
    advance();
    vectors++;
    if (pc !== 32'h500) begin miscompares++; $display("FAIL wait_replace: pc=%h, want 00000500", pc); end
    imem_ready = 0; br_taken = 1; br_target = 32'h600;
    advance(); clear_inputs();
    trap_req = 1;
    advance(); clear_inputs(); imem_ready = 1;
    vectors++;
    if (pc_valid !== 1'b0 || epc !== 32'h500) begin
      miscompares++; $display("FAIL wait_trap: valid=%b epc=%h, want 0 00000500", pc_valid, epc);
    end
    advance();
    vectors++;
    if (pc !== TRAP_V) begin miscompares++; $display("FAIL wait_trap_exit: pc=%h, want %h", pc, TRAP_V); end
  endtask

  task automatic test_reset_mid_wait();
    imem_ready = 0; br_taken = 1; br_target = 32'h700;
    advance(); clear_inputs();
    n_rst = 0; model_reset();
    #1;
    vectors++;
    if (pc !== RST_V || pc_valid !== 1'b0 || epc !== 32'h0) begin
      miscompares++; $display("FAIL async_reset: pc=%h valid=%b epc=%h, want %h 0 0", pc, pc_valid, epc, RST_V);
    end
    advance();
    n_rst = 1; imem_ready = 1;
    advance(); advance();
    vectors++;
    if (pc !== RST_V + 32'd4) begin miscompares++; $display("FAIL reset_discard: pc=%h, want %h", pc, RST_V + 32'd4); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 800; i++) begin
      clear_inputs();
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      trap_req   = ($urandom_range(0, 39) == 0);
      mret       = ($urandom_range(0, 29) == 0);
      jalr_en    = ($urandom_range(0, 11) == 0);
      br_taken   = ($urandom_range(0, 7) == 0);
      r = $urandom();
      br_target  = ($urandom_range(0, 7) == 0) ? r : (r & ~32'h3);
      jalr_base  = $urandom() & ~32'h3;
      jalr_imm   = $urandom_range(0, 63);
      if ($urandom_range(0, 199) == 0) begin
        n_rst = 0; model_reset(); #1;
      end
      advance();
      n_rst = 1;
      vectors++;
      if (pc !== m_pc || pc_valid !== !(m_boot || m_trap) || epc !== m_epc ||
          misalign !== m_mis || pc_plus4 !== m_pc + 32'd4) begin
        miscompares++;
        $display("FAIL rand[%0d]: pc=%h valid=%b epc=%h mis=%b p4=%h, want %h %b %h %b %h",
                 i, pc, pc_valid, epc, misalign, pc_plus4,
                 m_pc, !(m_boot || m_trap), m_epc, m_mis, m_pc + 32'd4);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_redirects();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
